// File: rtl/filter_read_controller.sv
//------------------------------------------------------------------------------
// filter_read_controller: sequences one scratchpad read per element of every
// filter in a job and drives the filter address generator strobes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module filter_read_controller #(
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int NUM_FILTERS_REG_SIZE = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size_i,
  input  logic [NUM_FILTERS_REG_SIZE-1:0] num_filters_i,
  input  logic                            filter_valid_i,
  input  logic                            pe_ready_i,
  output logic                            read_en_o,
  output logic                            put_filter_o,
  output logic                            next_filter_o,
  output logic                            end_of_filter_o,
  output logic [NUM_FILTERS_REG_SIZE-1:0] filter_idx_o,
  output logic [FILTER_SIZE_REG_SIZE-1:0] elem_idx_o,
  output logic                            last_elem_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam logic [FILTER_SIZE_REG_SIZE-1:0] FS_ONE = {{(FILTER_SIZE_REG_SIZE-1){1'b0}}, 1'b1};
  localparam logic [NUM_FILTERS_REG_SIZE-1:0] NF_ONE = {{(NUM_FILTERS_REG_SIZE-1){1'b0}}, 1'b1};
  localparam logic [FILTER_SIZE_REG_SIZE-1:0] FS_ZERO = '0;
  localparam logic [NUM_FILTERS_REG_SIZE-1:0] NF_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_STREAM  = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                            state_q, state_d;
  logic [FILTER_SIZE_REG_SIZE-1:0]   fsize_q, fsize_d;
  logic [FILTER_SIZE_REG_SIZE-1:0]   elem_q, elem_d;
  logic [NUM_FILTERS_REG_SIZE-1:0]   nfilt_q, nfilt_d;
  logic [NUM_FILTERS_REG_SIZE-1:0]   filt_q, filt_d;

  logic read_w;
  logic at_last_elem_w;
  logic at_last_filter_w;

  // Full-width compares against latched config minus one, so a size of
  // all-ones never needs the counter to wrap.
  assign read_w           = (state_q == S_STREAM) && pe_ready_i;
  assign at_last_elem_w   = (elem_q == (fsize_q - FS_ONE));
  assign at_last_filter_w = (filt_q == (nfilt_q - NF_ONE));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      fsize_q <= FS_ZERO;
      elem_q  <= FS_ZERO;
      nfilt_q <= NF_ZERO;
      filt_q  <= NF_ZERO;
    end else begin
      state_q <= state_d;
      fsize_q <= fsize_d;
      elem_q  <= elem_d;
      nfilt_q <= nfilt_d;
      filt_q  <= filt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fsize_d = fsize_q;
    elem_d  = elem_q;
    nfilt_d = nfilt_q;
    filt_d  = filt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ((filter_size_i != FS_ZERO) && (num_filters_i != NF_ZERO)) begin
            fsize_d = filter_size_i;
            nfilt_d = num_filters_i;
            elem_d  = FS_ZERO;
            filt_d  = NF_ZERO;
            state_d = S_WAIT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (filter_valid_i) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (read_w) begin
          if (at_last_elem_w) begin
            elem_d  = FS_ZERO;
            state_d = S_ADVANCE;
          end else begin
            elem_d = elem_q + FS_ONE;
          end
        end
      end
      S_ADVANCE: begin
        if (at_last_filter_w) begin
          state_d = S_DONE;
        end else begin
          filt_d  = filt_q + NF_ONE;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        elem_d  = FS_ZERO;
        filt_d  = NF_ZERO;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      elem_d  = FS_ZERO;
      filt_d  = NF_ZERO;
      state_d = S_IDLE;
    end
  end

  assign read_en_o       = read_w;
  assign put_filter_o    = read_w;
  assign last_elem_o     = read_w && at_last_elem_w;
  assign next_filter_o   = (state_q == S_ADVANCE);
  assign end_of_filter_o = (state_q == S_ADVANCE) && at_last_filter_w;
  assign filter_idx_o    = filt_q;
  assign elem_idx_o      = elem_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_filter_read_controller.sv
//------------------------------------------------------------------------------
// tb_filter_read_controller: per-cycle vector table plus async-reset sequence.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_filter_read_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] filter_size = 8'd0;
  logic [7:0] num_filters = 8'd0;
  logic       filter_valid = 1'b0;
  logic       pe_ready = 1'b0;
  logic       read_en, put_filter, next_filter, end_of_filter, last_elem, busy, done;
  logic [7:0] filter_idx, elem_idx;

  int checks = 0;
  int errors = 0;

  filter_read_controller #(
    .FILTER_SIZE_REG_SIZE(8),
    .NUM_FILTERS_REG_SIZE(8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .filter_size_i  (filter_size),
    .num_filters_i  (num_filters),
    .filter_valid_i (filter_valid),
    .pe_ready_i     (pe_ready),
    .read_en_o      (read_en),
    .put_filter_o   (put_filter),
    .next_filter_o  (next_filter),
    .end_of_filter_o(end_of_filter),
    .filter_idx_o   (filter_idx),
    .elem_idx_o     (elem_idx),
    .last_elem_o    (last_elem),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, ab;
    logic [7:0] fs, nf;
    logic       fv, pe;
    logic       rd, lst, nx, eof, bsy, dn;
    logic [7:0] fi, ei;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int st, input int ab, input int fs, input int nf,
                     input int fv, input int pe,
                     input int rd, input int lst, input int nx, input int eof,
                     input int bsy, input int dn, input int fi, input int ei);
    vec_t v;
    v.st = st[0];  v.ab = ab[0];  v.fs = fs[7:0]; v.nf = nf[7:0];
    v.fv = fv[0];  v.pe = pe[0];
    v.rd = rd[0];  v.lst = lst[0]; v.nx = nx[0]; v.eof = eof[0];
    v.bsy = bsy[0]; v.dn = dn[0]; v.fi = fi[7:0]; v.ei = ei[7:0];
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic rd, input logic lst, input logic nx,
                             input logic eof, input logic bsy, input logic dn,
                             input logic [7:0] fi, input logic [7:0] ei);
    chk(idx, "read_en",       8'(read_en),       8'(rd));
    chk(idx, "put_filter",    8'(put_filter),    8'(rd));
    chk(idx, "last_elem",     8'(last_elem),     8'(lst));
    chk(idx, "next_filter",   8'(next_filter),   8'(nx));
    chk(idx, "end_of_filter", 8'(end_of_filter), 8'(eof));
    chk(idx, "busy",          8'(busy),          8'(bsy));
    chk(idx, "done",          8'(done),          8'(dn));
    chk(idx, "filter_idx",    filter_idx,        fi);
    chk(idx, "elem_idx",      elem_idx,          ei);
  endtask

  initial begin
    // Nominal S=3 N=2; config changed to 9/9 after start must be ignored.
    add(1,0,3,2,1,1, 0,0,0,0,0,0,0,0);
    add(0,0,9,9,1,1, 0,0,0,0,1,0,0,0);
    add(0,0,9,9,1,1, 1,0,0,0,1,0,0,0);
    add(1,0,9,9,1,1, 1,0,0,0,1,0,0,1);
    add(0,0,9,9,1,1, 1,1,0,0,1,0,0,2);
    add(0,0,9,9,1,1, 0,0,1,0,1,0,0,0);
    add(0,0,9,9,1,1, 0,0,0,0,1,0,1,0);
    add(0,0,9,9,1,1, 1,0,0,0,1,0,1,0);
    add(0,0,9,9,1,1, 1,0,0,0,1,0,1,1);
    add(0,0,9,9,1,1, 1,1,0,0,1,0,1,2);
    add(0,0,9,9,1,1, 0,0,1,1,1,0,1,0);
    add(0,0,9,9,1,1, 0,0,0,0,1,1,1,0);
    add(0,0,9,9,1,1, 0,0,0,0,0,0,0,0);
    // Backpressure S=4 N=1, pe_ready low on cycles 3-5.
    add(1,0,4,1,1,1, 0,0,0,0,0,0,0,0);
    add(0,0,4,1,1,1, 0,0,0,0,1,0,0,0);
    add(0,0,4,1,1,1, 1,0,0,0,1,0,0,0);
    add(0,0,4,1,1,0, 0,0,0,0,1,0,0,1);
    add(0,0,4,1,1,0, 0,0,0,0,1,0,0,1);
    add(0,0,4,1,1,0, 0,0,0,0,1,0,0,1);
    add(0,0,4,1,1,1, 1,0,0,0,1,0,0,1);
    add(0,0,4,1,1,1, 1,0,0,0,1,0,0,2);
    add(0,0,4,1,1,1, 1,1,0,0,1,0,0,3);
    add(0,0,4,1,1,1, 0,0,1,1,1,0,0,0);
    add(0,0,4,1,1,1, 0,0,0,0,1,1,0,0);
    add(0,0,4,1,1,1, 0,0,0,0,0,0,0,0);
    // Fill stall S=2 N=2, filter_valid low 5-8; dropping it mid-STREAM is ignored.
    add(1,0,2,2,1,1, 0,0,0,0,0,0,0,0);
    add(0,0,2,2,1,1, 0,0,0,0,1,0,0,0);
    add(0,0,2,2,1,1, 1,0,0,0,1,0,0,0);
    add(0,0,2,2,1,1, 1,1,0,0,1,0,0,1);
    add(0,0,2,2,1,1, 0,0,1,0,1,0,0,0);
    add(0,0,2,2,0,1, 0,0,0,0,1,0,1,0);
    add(0,0,2,2,0,1, 0,0,0,0,1,0,1,0);
    add(0,0,2,2,0,1, 0,0,0,0,1,0,1,0);
    add(0,0,2,2,0,1, 0,0,0,0,1,0,1,0);
    add(0,0,2,2,1,1, 0,0,0,0,1,0,1,0);
    add(0,0,2,2,1,1, 1,0,0,0,1,0,1,0);
    add(0,0,2,2,0,1, 1,1,0,0,1,0,1,1);
    add(0,0,2,2,1,1, 0,0,1,1,1,0,1,0);
    add(0,0,2,2,1,1, 0,0,0,0,1,1,1,0);
    add(0,0,2,2,1,1, 0,0,0,0,0,0,0,0);
    // Zero config: num_filters=0, then filter_size=0.
    add(1,0,5,0,1,1, 0,0,0,0,0,0,0,0);
    add(0,0,5,0,1,1, 0,0,0,0,1,1,0,0);
    add(0,0,5,0,1,1, 0,0,0,0,0,0,0,0);
    add(1,0,0,3,1,1, 0,0,0,0,0,0,0,0);
    add(0,0,0,3,1,1, 0,0,0,0,1,1,0,0);
    add(0,0,0,3,1,1, 0,0,0,0,0,0,0,0);
    // Abort S=3 N=2 at cycle 7, restart at 9 with S=1 N=1.
    add(1,0,3,2,1,1, 0,0,0,0,0,0,0,0);
    add(0,0,3,2,1,1, 0,0,0,0,1,0,0,0);
    add(0,0,3,2,1,1, 1,0,0,0,1,0,0,0);
    add(0,0,3,2,1,1, 1,0,0,0,1,0,0,1);
    add(0,0,3,2,1,1, 1,1,0,0,1,0,0,2);
    add(0,0,3,2,1,1, 0,0,1,0,1,0,0,0);
    add(0,0,3,2,1,1, 0,0,0,0,1,0,1,0);
    add(0,1,3,2,1,1, 1,0,0,0,1,0,1,0);
    add(0,0,3,2,1,1, 0,0,0,0,0,0,0,0);
    add(1,0,1,1,1,1, 0,0,0,0,0,0,0,0);
    add(0,0,1,1,1,1, 0,0,0,0,1,0,0,0);
    add(0,0,1,1,1,1, 1,1,0,0,1,0,0,0);
    add(0,0,1,1,1,1, 0,0,1,1,1,0,0,0);
    add(0,0,1,1,1,1, 0,0,0,0,1,1,0,0);
    add(0,0,1,1,1,1, 0,0,0,0,0,0,0,0);

    #2;
    chk_outputs(-1, 0,0,0,0,0,0,8'd0,8'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start        = vecs[i].st;
      abort        = vecs[i].ab;
      filter_size  = vecs[i].fs;
      num_filters  = vecs[i].nf;
      filter_valid = vecs[i].fv;
      pe_ready     = vecs[i].pe;
      #1;
      chk_outputs(i, vecs[i].rd, vecs[i].lst, vecs[i].nx, vecs[i].eof,
                  vecs[i].bsy, vecs[i].dn, vecs[i].fi, vecs[i].ei);
    end

    // Async reset mid-STREAM, then a fresh S=5 N=1 job.
    @(negedge clk);
    start = 1'b1; abort = 1'b0; filter_size = 8'd5; num_filters = 8'd1;
    filter_valid = 1'b1; pe_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk(1000, "stream_before_reset", 8'(read_en), 8'd1);
    #1 rst_n = 1'b0;
    #1 chk_outputs(1001, 0,0,0,0,0,0,8'd0,8'd0);
    @(negedge clk);
    #1 chk_outputs(1002, 0,0,0,0,0,0,8'd0,8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk(1003, "idle_without_start", 8'(busy), 8'd0);
    @(negedge clk);
    start = 1'b1;
    begin
      int first_rd = -1;
      int done_cyc = -1;
      int nreads = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        start = 1'b0;
        #1;
        if (read_en) begin
          nreads++;
          if (first_rd < 0) first_rd = c;
        end
        if (done && done_cyc < 0) done_cyc = c;
      end
      chk(1004, "post_reset_first_read_cycle", 8'(first_rd), 8'd2);
      chk(1005, "post_reset_done_cycle",       8'(done_cyc), 8'd8);
      chk(1006, "post_reset_read_count",       8'(nreads),   8'd5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/filter_read_controller.md
# filter_read_controller

Sequencing FSM for the filter-scratchpad read address generator in the convolution datapath. It accepts a job descriptor (filter size, filter count) and steps through every element of every filter, one read per accepted cycle. It drives the generator's `put_filter`, `next_filter` and `end_of_filter` strobes and handshakes with the filter-buffer fill logic (`filter_valid`) and the PE (`pe_ready`). Filter indices go to the PE for bookkeeping.

## Interface
- `FILTER_SIZE_REG_SIZE`, 8: width of `filter_size` and `elem_idx`.
- `NUM_FILTERS_REG_SIZE`, 8: width of `num_filters` and `filter_idx`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `abort`  in  1  synchronous job cancel.
- `filter_size`  in  FILTER_SIZE_REG_SIZE  elements per filter; latched on accepted start.
- `num_filters`  in  NUM_FILTERS_REG_SIZE  filters per job; latched on accepted start.
- `filter_valid`  in  1  current filter fully resident in scratchpad.
- `pe_ready`  in  1  PE accepts an element this cycle.
- `read_en`  out  1  scratchpad read issued this cycle.
- `put_filter`  out  1  to address generator; equals `read_en`.
- `next_filter`  out  1  to address generator; one-cycle pulse per finished filter.
- `end_of_filter`  out  1  to address generator; high with the final `next_filter` only.
- `filter_idx`  out  NUM_FILTERS_REG_SIZE  index of the filter being read.
- `elem_idx`  out  FILTER_SIZE_REG_SIZE  index of the element read this cycle.
- `last_elem`  out  1  `read_en` on the last element of a filter.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, WAIT, STREAM, ADVANCE, DONE.
- Reset: state IDLE. All counters and latched config are 0. Every output is 0.
- **IDLE**
  - `start`=1 with both `filter_size`≠0 and `num_filters`≠0: latch both values, clear counters, go to WAIT.
  - `start`=1 with either value 0: go to DONE. No reads are issued.
- **WAIT**
  - Hold while `filter_valid`=0.
  - `filter_valid`=1: go to STREAM next cycle.
- **STREAM**
  - `read_en` = `pe_ready` (combinational, STREAM only).
  - Each `read_en` cycle: `elem_idx` increments after the read.
  - `pe_ready`=0: hold with no read. `elem_idx` is stable.
  - Read with `elem_idx`=`filter_size`-1: `last_elem`=1, `elem_idx` clears to 0, go to ADVANCE.
  - `filter_valid` is not rechecked during STREAM.
- **ADVANCE** (exactly one cycle)
  - `next_filter`=1.
  - If `filter_idx`=`num_filters`-1: `end_of_filter`=1, go to DONE.
  - Otherwise: `filter_idx` increments, go to WAIT.
- **DONE**
  - `done`=1 for one cycle, `busy`=1, then go to IDLE.
  - `filter_idx` clears on the return to IDLE.
- **abort**
  - `abort`=1 in any non-IDLE state: go to IDLE next edge and clear counters. No `done`, no `next_filter`.
  - If `abort` coincides with a STREAM read, that read still shows on `read_en` in that cycle.
  - `abort` has priority over all other transitions.
- `start` outside IDLE is ignored.
- Config input changes after the accepted start are ignored until the next job.
- Counters never wrap:
  - Maximum `filter_size` and `num_filters` are 2^width−1.
  - `elem_idx` compares against latched `filter_size`-1 at full width.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
- With `filter_valid` and `pe_ready` held high, each filter takes S+2 cycles:
  - filter k WAIT at cycle 1+k(S+2);
  - STREAM for S cycles;
  - ADVANCE at (k+1)(S+2).
- `done` is high at cycle N(S+2)+1.
- First `read_en` occurs at cycle 2.
- Zero-size job: `done` at cycle 1.
- All outputs are registered-state decodes, except `read_en`/`put_filter`/`last_elem`, which are gated combinationally by `pe_ready`.
- Async reset mid-job: all outputs go to 0 immediately. The next job needs a fresh `start`.

## Test plan
- Reset: assert `rst`=0 mid-STREAM → all outputs 0 immediately, state IDLE; `start` after release runs a full job.
- Nominal, S=3, N=2, `filter_valid`=`pe_ready`=1:
  - `read_en` at cycles 2,3,4,7,8,9 with `elem_idx` 0,1,2,0,1,2;
  - `next_filter` at 5 and 10;
  - `end_of_filter` only at 10;
  - `done` at 11.
- Backpressure, S=4, N=1, `pe_ready` low on cycles 3–5 → reads at cycles 2,6,7,8; `last_elem` at 8; `done` at 10.
- Fill stall, S=2, N=2, `filter_valid` drops at cycle 5 and rises at cycle 9 → second filter's reads at cycles 10,11; `done` at 13.
- Zero config, `start` with `num_filters`=0 → no `read_en`, `done` at cycle 1, `busy` high at cycle 1 only.
- Abort, S=3, N=2, `abort` at cycle 7 → IDLE at 8, no further `next_filter`, `done` never asserted; a new `start` at 9 gives its first read at 11.
